spin_run_sequencer: RTL and testbench

Sequences the Ising core through its programmed runs and reruns. Per run: spin init, annealing (CCII enable), settle window, one-cycle spin read-out strobe into the output spin RF. Stalls on output-buffer full. Asserts final_run once all results are captured, which hands the RF to the GPIO read-out path. Sits between the system config registers and the spin array / output spin RF controller.

---
 rtl/spin_run_sequencer_if.sv | 39 +++
 rtl/spin_run_sequencer.sv | 96 +++++++++
 tb/tb_spin_run_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spin_run_sequencer_if.sv
// spin_run_sequencer_if: config-register inputs and spin-array / output-RF strobes of the run sequencer
interface spin_run_sequencer_if #(
    parameter int CNT_W    = 8,
    parameter int ANNEAL_W = 16,
    parameter int SETTLE_W = 8
);
    logic                conf_sys_ctrl_reg_START;
    logic                conf_sys_ctrl_reg_RESET;
    logic [CNT_W-1:0]    conf_reg_total_run_count;
    logic [CNT_W-1:0]    conf_reg_total_rerun_count;
    logic [ANNEAL_W-1:0] conf_reg_anneal_cycles;
    logic [SETTLE_W-1:0] conf_reg_settle_cycles;
    logic                output_spin_rf_gpio_buffer_full;
    logic                config_dig_spin_init_ena;
    logic                config_dig_spin_CCII_ena;
    logic                config_dig_spin_read_out_ena;
    logic                config_dig_spin_rerun;
    logic                final_run;
    logic [CNT_W-1:0]    run_idx;
    logic                busy;
    logic                done_pulse;
    logic                err_overflow;

    modport master (
        output conf_sys_ctrl_reg_START, conf_sys_ctrl_reg_RESET, conf_reg_total_run_count,
               conf_reg_total_rerun_count, conf_reg_anneal_cycles, conf_reg_settle_cycles,
               output_spin_rf_gpio_buffer_full,
        input  config_dig_spin_init_ena, config_dig_spin_CCII_ena, config_dig_spin_read_out_ena,
               config_dig_spin_rerun, final_run, run_idx, busy, done_pulse, err_overflow
    );

    modport slave (
        input  conf_sys_ctrl_reg_START, conf_sys_ctrl_reg_RESET, conf_reg_total_run_count,
               conf_reg_total_rerun_count, conf_reg_anneal_cycles, conf_reg_settle_cycles,
               output_spin_rf_gpio_buffer_full,
        output config_dig_spin_init_ena, config_dig_spin_CCII_ena, config_dig_spin_read_out_ena,
               config_dig_spin_rerun, final_run, run_idx, busy, done_pulse, err_overflow
    );
endinterface

// File: rtl/spin_run_sequencer.sv
// spin_run_sequencer: steps the Ising core through init, anneal, settle and read-out for every run and rerun
module spin_run_sequencer #(
    parameter int CNT_W       = 8,
    parameter int ANNEAL_W    = 16,
    parameter int SETTLE_W    = 8,
    parameter int MAX_ENTRIES = 200
) (
    input logic                 i_clk,
    input logic                 i_rst,
    spin_run_sequencer_if.slave bus
);
    localparam int CW = ANNEAL_W > SETTLE_W ? ANNEAL_W : SETTLE_W;
    localparam logic [CNT_W:0] MAX_T = (CNT_W + 1)'(MAX_ENTRIES);

    typedef enum logic [2:0] {IDLE, INIT, ANNEAL, SETTLE, READOUT, NEXT, DONE} state_t;

    state_t              state, nxt;
    logic                start_q, reset_q, start_e, reset_e;
    logic [CNT_W:0]      total, tot_sh;
    logic [CNT_W-1:0]    run_sh;
    logic [ANNEAL_W-1:0] anneal_sh;
    logic [SETTLE_W-1:0] settle_sh;
    logic [CW-1:0]       cnt, a_len;
    logic                a_end, s_end, all_done, latch, to_rerun;

    assign start_e  = bus.conf_sys_ctrl_reg_START & ~start_q;
    assign reset_e  = bus.conf_sys_ctrl_reg_RESET & ~reset_q;
    assign total    = {1'b0, bus.conf_reg_total_run_count} + {1'b0, bus.conf_reg_total_rerun_count};
    assign a_len    = anneal_sh == '0 ? CW'(1) : CW'(anneal_sh);
    assign a_end    = cnt >= a_len;
    assign s_end    = cnt >= CW'(settle_sh);
    assign all_done = {1'b0, bus.run_idx} == tot_sh;
    assign latch    = state == IDLE && (nxt == INIT || nxt == ANNEAL);
    assign to_rerun = nxt == ANNEAL && (state == IDLE || state == NEXT);

    // next-state selection; a RESET edge overrides every transition, including a same-cycle START
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !start_e ? IDLE : total > MAX_T ? IDLE : total == '0 ? DONE :
                           bus.conf_reg_total_run_count != '0 ? INIT : ANNEAL;
            INIT:    nxt = ANNEAL;
            ANNEAL:  nxt = !a_end ? ANNEAL : settle_sh == '0 ? READOUT : SETTLE;
            SETTLE:  nxt = s_end ? READOUT : SETTLE;
            READOUT: nxt = NEXT;
            NEXT:    nxt = all_done ? DONE : bus.output_spin_rf_gpio_buffer_full ? NEXT :
                           bus.run_idx < run_sh ? INIT : ANNEAL;
            default: nxt = DONE;
        endcase
        if (reset_e) nxt = IDLE;
    end

    // state, shadows, counters and Moore outputs registered from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                            <= IDLE;
            start_q                          <= 1'b0;
            reset_q                          <= 1'b0;
            tot_sh                           <= '0;
            run_sh                           <= '0;
            anneal_sh                        <= '0;
            settle_sh                        <= '0;
            cnt                              <= '0;
            bus.run_idx                      <= '0;
            bus.err_overflow                 <= 1'b0;
            bus.config_dig_spin_init_ena     <= 1'b0;
            bus.config_dig_spin_CCII_ena     <= 1'b0;
            bus.config_dig_spin_read_out_ena <= 1'b0;
            bus.config_dig_spin_rerun        <= 1'b0;
            bus.final_run                    <= 1'b0;
            bus.busy                         <= 1'b0;
            bus.done_pulse                   <= 1'b0;
        end else begin
            state     <= nxt;
            start_q   <= bus.conf_sys_ctrl_reg_START;
            reset_q   <= bus.conf_sys_ctrl_reg_RESET;
            tot_sh    <= reset_e ? '0 : latch ? total : tot_sh;
            run_sh    <= reset_e ? '0 : latch ? bus.conf_reg_total_run_count : run_sh;
            anneal_sh <= reset_e ? '0 : latch ? bus.conf_reg_anneal_cycles : anneal_sh;
            settle_sh <= reset_e ? '0 : latch ? bus.conf_reg_settle_cycles : settle_sh;
            cnt       <= reset_e ? '0 : nxt == state ? cnt + 1'b1 : CW'(1);
            bus.run_idx <= reset_e || latch ? '0 :
                           state == READOUT && !all_done ? bus.run_idx + 1'b1 : bus.run_idx;
            bus.err_overflow <= reset_e ? 1'b0 :
                                state == IDLE && start_e && total > MAX_T ? 1'b1 : bus.err_overflow;
            bus.config_dig_spin_init_ena     <= nxt == INIT;
            bus.config_dig_spin_CCII_ena     <= nxt == ANNEAL;
            bus.config_dig_spin_read_out_ena <= nxt == READOUT;
            bus.config_dig_spin_rerun        <= to_rerun ? 1'b1 :
                                                nxt == IDLE || nxt == DONE ? 1'b0 : bus.config_dig_spin_rerun;
            bus.final_run                    <= nxt == DONE;
            bus.busy                         <= nxt != IDLE && nxt != DONE;
            bus.done_pulse                   <= nxt == DONE && state != DONE;
        end
    end
endmodule

// File: tb/tb_spin_run_sequencer.sv
// tb_spin_run_sequencer: randomized and directed run sequences scored against a timeline model of the run rules
module tb_spin_run_sequencer;
    localparam int CNT_W = 8;
    localparam int ANNEAL_W = 16;
    localparam int SETTLE_W = 8;

    typedef struct {
        bit done;
        int t;
        int cc;
        int in;
        bit rr;
        int idx;
    } exp_t;

    logic i_clk, i_rst;
    int   cyc, checks, errors, n_cc, n_in;
    exp_t q[$];
    int   stall_q[$];

    spin_run_sequencer_if #(.CNT_W(CNT_W), .ANNEAL_W(ANNEAL_W), .SETTLE_W(SETTLE_W)) bus ();

    spin_run_sequencer #(.CNT_W(CNT_W), .ANNEAL_W(ANNEAL_W), .SETTLE_W(SETTLE_W), .MAX_ENTRIES(200)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: invariants every cycle, and a scoreboard pop on every read-out strobe or done pulse
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            chk("ro_ccii_excl", bus.config_dig_spin_read_out_ena & bus.config_dig_spin_CCII_ena, 0);
            chk("init_excl", bus.config_dig_spin_init_ena &
                (bus.config_dig_spin_read_out_ena | bus.config_dig_spin_CCII_ena), 0);
            if (!bus.busy) begin
                n_cc = 0;
                n_in = 0;
            end
            n_cc += int'(bus.config_dig_spin_CCII_ena);
            n_in += int'(bus.config_dig_spin_init_ena);
            if (bus.config_dig_spin_read_out_ena || bus.done_pulse) begin
                chk("evt_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (e.done) begin
                        chk("done_pulse", bus.done_pulse, 1);
                        chk("done_cycle", cyc, e.t);
                        chk("done_run_idx", bus.run_idx, e.idx);
                        chk("done_final", bus.final_run, 1);
                        chk("done_rerun", bus.config_dig_spin_rerun, 0);
                        chk("done_busy", bus.busy, 0);
                    end else begin
                        chk("ro_strobe", bus.config_dig_spin_read_out_ena, 1);
                        chk("ro_cycle", cyc, e.t);
                        chk("ro_ccii_cycles", n_cc, e.cc);
                        chk("ro_init_cycles", n_in, e.in);
                        chk("ro_rerun", bus.config_dig_spin_rerun, e.rr);
                        chk("ro_run_idx", bus.run_idx, e.idx);
                    end
                end
                if (bus.config_dig_spin_read_out_ena) begin
                    n_cc = 0;
                    n_in = 0;
                end
            end
        end
    end

    // output-RF stand-in: after a read-out, reports full for the planned number of cycles
    initial begin
        int n;
        bus.output_spin_rf_gpio_buffer_full = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst && bus.config_dig_spin_read_out_ena) begin
                n = stall_q.size() > 0 ? stall_q.pop_front() : 0;
                if (n > 0) begin
                    bus.output_spin_rf_gpio_buffer_full = 1'b1;
                    repeat (n + 1) @(negedge i_clk);
                    bus.output_spin_rf_gpio_buffer_full = 1'b0;
                end
            end
        end
    end

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() > 0 && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain_left", q.size(), 0);
        q.delete();
    endtask

    task automatic reset_edge();
        @(negedge i_clk);
        bus.conf_sys_ctrl_reg_RESET = 1'b1;
        @(negedge i_clk);
        bus.conf_sys_ctrl_reg_RESET = 1'b0;
        chk("rst_final", bus.final_run, 0);
        chk("rst_run_idx", bus.run_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_overflow, 0);
        chk("rst_rerun", bus.config_dig_spin_rerun, 0);
    endtask

    // mode 0: no stall, 1: 10-cycle stall after first read-out, 2: random stalls, 3: registers altered after START
    // lim < 0 scores the whole sequence; otherwise only the first lim read-outs
    task automatic run_seq(input int r, input int rr, input int a, input int s, input int mode, input int lim);
        int   tot, aeff, t, n;
        int   st[$];
        exp_t e;
        tot  = r + rr;
        aeff = a == 0 ? 1 : a;
        for (int k = 0; k < tot; k++)
            st.push_back(k == tot - 1 ? 0 : mode == 1 && k == 0 ? 10 :
                         mode == 2 && $urandom_range(2) == 0 ? int'($urandom_range(5, 1)) : 0);
        @(negedge i_clk);
        bus.conf_reg_total_run_count   = CNT_W'(r);
        bus.conf_reg_total_rerun_count = CNT_W'(rr);
        bus.conf_reg_anneal_cycles     = ANNEAL_W'(a);
        bus.conf_reg_settle_cycles     = SETTLE_W'(s);
        bus.conf_sys_ctrl_reg_START    = 1'b1;
        stall_q = st;
        t = cyc + 1;
        n = lim < 0 ? tot : lim;
        if (tot == 0 && lim < 0) q.push_back('{done: 1'b1, t: t, cc: 0, in: 0, rr: 1'b0, idx: 0});
        for (int k = 0; k < n; k++) begin
            if (k < r) t++;
            e = '{done: 1'b0, t: t + aeff + s, cc: aeff, in: k < r ? 1 : 0, rr: k >= r, idx: k};
            q.push_back(e);
            if (k == tot - 1) q.push_back('{done: 1'b1, t: e.t + 2, cc: 0, in: 0, rr: 1'b0, idx: tot});
            t = e.t + 2 + st[k];
        end
        @(negedge i_clk);
        bus.conf_sys_ctrl_reg_START = 1'b0;
        if (mode == 3) begin
            bus.conf_reg_anneal_cycles   = ANNEAL_W'(a + 7);
            bus.conf_reg_settle_cycles   = SETTLE_W'(s + 3);
            bus.conf_reg_total_run_count = CNT_W'(r + 1);
        end
        drain(3000);
        if (lim < 0) begin
            @(negedge i_clk);
            bus.conf_sys_ctrl_reg_START = 1'b1;
            @(negedge i_clk);
            bus.conf_sys_ctrl_reg_START = 1'b0;
            repeat (2) @(negedge i_clk);
            chk("done_hold_final", bus.final_run, 1);
            chk("done_hold_idx", bus.run_idx, tot);
            chk("done_hold_busy", bus.busy, 0);
        end
    endtask

    initial begin
        int r, rr, a, s;
        checks = 0;
        errors = 0;
        n_cc = 0;
        n_in = 0;
        bus.conf_sys_ctrl_reg_START    = 1'b0;
        bus.conf_sys_ctrl_reg_RESET    = 1'b0;
        bus.conf_reg_total_run_count   = '0;
        bus.conf_reg_total_rerun_count = '0;
        bus.conf_reg_anneal_cycles     = '0;
        bus.conf_reg_settle_cycles     = '0;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("por_busy", bus.busy, 0);
        chk("por_final", bus.final_run, 0);
        chk("por_run_idx", bus.run_idx, 0);
        chk("por_err", bus.err_overflow, 0);
        chk("por_strobes", {bus.config_dig_spin_init_ena, bus.config_dig_spin_CCII_ena,
                            bus.config_dig_spin_read_out_ena, bus.config_dig_spin_rerun, bus.done_pulse}, 0);
        i_rst = 1'b0;

        run_seq(2, 1, 3, 2, 0, -1);
        reset_edge();
        run_seq(0, 0, 3, 2, 0, -1);
        reset_edge();

        @(negedge i_clk);
        bus.conf_reg_total_run_count   = 8'd150;
        bus.conf_reg_total_rerun_count = 8'd51;
        bus.conf_sys_ctrl_reg_START    = 1'b1;
        @(negedge i_clk);
        bus.conf_sys_ctrl_reg_START = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("ovf_err", bus.err_overflow, 1);
        chk("ovf_busy", bus.busy, 0);
        chk("ovf_final", bus.final_run, 0);
        reset_edge();
        run_seq(150, 50, 1, 0, 0, -1);
        reset_edge();

        run_seq(3, 0, 1, 0, 1, -1);
        reset_edge();

        run_seq(3, 0, 20, 2, 0, 1);
        repeat (4) @(negedge i_clk);
        chk("mid_anneal_ccii", bus.config_dig_spin_CCII_ena, 1);
        bus.conf_sys_ctrl_reg_RESET = 1'b1;
        @(negedge i_clk);
        chk("abort_ccii", bus.config_dig_spin_CCII_ena, 0);
        chk("abort_run_idx", bus.run_idx, 0);
        chk("abort_busy", bus.busy, 0);
        bus.conf_sys_ctrl_reg_RESET = 1'b0;
        @(negedge i_clk);
        bus.conf_reg_total_run_count = 8'd2;
        bus.conf_sys_ctrl_reg_START  = 1'b1;
        bus.conf_sys_ctrl_reg_RESET  = 1'b1;
        @(negedge i_clk);
        bus.conf_sys_ctrl_reg_START = 1'b0;
        bus.conf_sys_ctrl_reg_RESET = 1'b0;
        chk("both_edges_init", bus.config_dig_spin_init_ena, 0);
        chk("both_edges_busy", bus.busy, 0);
        repeat (3) @(negedge i_clk);
        chk("both_edges_idle", bus.busy, 0);

        run_seq(1, 0, 2, 30, 0, 0);
        repeat (6) @(negedge i_clk);
        chk("settle_busy", bus.busy, 1);
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_strobes", {bus.config_dig_spin_init_ena, bus.config_dig_spin_CCII_ena,
                             bus.config_dig_spin_read_out_ena, bus.config_dig_spin_rerun, bus.done_pulse}, 0);
        chk("arst_final", bus.final_run, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_seq(2, 1, 4, 1, 3, -1);
        reset_edge();

        for (int i = 0; i < 10; i++) begin
            r  = int'($urandom_range(5));
            rr = int'($urandom_range(3));
            a  = int'($urandom_range(4));
            s  = int'($urandom_range(3));
            run_seq(r, rr, a, s, $urandom_range(1) == 0 ? 0 : 2, -1);
            reset_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
